// File: rtl/data_store_buffer.sv
// data_store_buffer: store FIFO plus a single-load holder in front of the
// data-side RAM interface. All CPU traffic is serialised into one
// call_begin / return_ready transaction at a time.
// Build option: define SB_LOAD_BYPASS_EN to let a held load pass queued
// stores that target other words (address comparators on every FIFO slot).
module data_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cpu_req_valid,
  input  logic             cpu_req_we,
  input  logic [2:0]       cpu_req_size,
  input  logic [31:0]      cpu_req_addr,
  input  logic [31:0]      cpu_req_wdata,
  output logic             cpu_req_ready,
  output logic             cpu_rdata_valid,
  output logic [31:0]      cpu_rdata,
  output logic             sb_empty,
  output logic [PTR_W:0]   sb_count,
  output logic             write_enable,
  output logic [2:0]       read_size,
  output logic [2:0]       write_size,
  output logic [31:0]      data_interface_raddr,
  output logic [31:0]      data_interface_waddr,
  output logic [31:0]      data_interface_wdata,
  output logic             data_interface_call_begin,
  input  logic             data_interface_return_ready,
  input  logic [31:0]      data_interface_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [PTR_W:0]   L_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   L_CNT_ONE = (PTR_W+1)'(1);

  state_t r_state, w_state_next;

  // store FIFO storage (no reset needed: occupancy qualifies every slot)
  logic [31:0] r_mem_addr [DEPTH];
  logic [31:0] r_mem_data [DEPTH];
  logic [2:0]  r_mem_size [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic        r_ld_valid;
  logic [31:0] r_ld_addr;
  logic [2:0]  r_ld_size;

  logic        r_is_load;   // type of the transaction currently in flight
  logic        r_active;    // low during and just after reset: keeps outputs at 0

  logic        r_call_begin, r_write_enable, r_rdata_valid;
  logic [2:0]  r_read_size, r_write_size;
  logic [31:0] r_raddr, r_waddr, r_wdata, r_rdata;

  logic w_full, w_empty, w_req_ready, w_push, w_ld_accept;
  logic w_load_elig, w_issue_load, w_issue_store, w_done, w_pop, w_ld_done;

  assign w_full      = (r_count == L_FULL);
  assign w_empty     = (r_count == '0);
  assign w_req_ready = r_active & (cpu_req_we ? !w_full : !r_ld_valid);
  assign w_push      = cpu_req_valid & w_req_ready & cpu_req_we;
  assign w_ld_accept = cpu_req_valid & w_req_ready & !cpu_req_we;
  assign w_pop       = w_done & !r_is_load;
  assign w_ld_done   = w_done & r_is_load;

`ifdef SB_LOAD_BYPASS_EN
  // one word-address comparator per slot, qualified by current occupancy
  logic [DEPTH-1:0] w_match;
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] w_off;
    assign w_off        = PTR_W'(gi) - r_rd_ptr;
    assign w_match[gi]  = ({1'b0, w_off} < r_count) &&
                          (r_mem_addr[gi][31:2] == r_ld_addr[31:2]);
  end
  assign w_load_elig = r_ld_valid & ~|w_match;
`else
  // strict drain: a load waits until every older store has completed
  assign w_load_elig = r_ld_valid & w_empty;
`endif

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // next-state and transaction selection
  always_comb begin
    w_state_next  = r_state;
    w_issue_load  = 1'b0;
    w_issue_store = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load_elig) begin
          w_issue_load = 1'b1;
          w_state_next = S_ISSUE;
        end else if (!w_empty) begin
          w_issue_store = 1'b1;
          w_state_next  = S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if (data_interface_return_ready) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FIFO storage write on push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= cpu_req_addr;
      r_mem_data[r_wr_ptr] <= cpu_req_wdata;
      r_mem_size[r_wr_ptr] <= cpu_req_size;
    end
  end

  // FIFO pointers, occupancy, load holder and output enable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ld_valid <= 1'b0;
      r_ld_addr  <= '0;
      r_ld_size  <= '0;
      r_active   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + L_CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - L_CNT_ONE;
      if (w_ld_accept) begin
        r_ld_valid <= 1'b1;
        r_ld_addr  <= cpu_req_addr;
        r_ld_size  <= cpu_req_size;
      end else if (w_ld_done) begin
        r_ld_valid <= 1'b0;
      end
    end
  end

  // registered interface and CPU outputs; held stable from ISSUE to return
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_call_begin   <= 1'b0;
      r_write_enable <= 1'b0;
      r_read_size    <= '0;
      r_write_size   <= '0;
      r_raddr        <= '0;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_is_load      <= 1'b0;
      r_rdata_valid  <= 1'b0;
      r_rdata        <= '0;
    end else begin
      r_call_begin  <= w_issue_load | w_issue_store;
      r_rdata_valid <= w_ld_done;
      if (w_ld_done) r_rdata <= data_interface_rdata;
      if (w_issue_store) begin
        r_write_enable <= 1'b1;
        r_waddr        <= r_mem_addr[r_rd_ptr];
        r_wdata        <= r_mem_data[r_rd_ptr];
        r_write_size   <= r_mem_size[r_rd_ptr];
        r_is_load      <= 1'b0;
      end else if (w_issue_load) begin
        r_write_enable <= 1'b0;
        r_raddr        <= r_ld_addr;
        r_read_size    <= r_ld_size;
        r_is_load      <= 1'b1;
      end
    end
  end

  assign cpu_req_ready             = w_req_ready;
  assign cpu_rdata_valid           = r_rdata_valid;
  assign cpu_rdata                 = r_rdata;
  assign sb_empty                  = r_active & w_empty & !r_ld_valid & (r_state == S_IDLE);
  assign sb_count                  = r_count;
  assign write_enable              = r_write_enable;
  assign read_size                 = r_read_size;
  assign write_size                = r_write_size;
  assign data_interface_raddr      = r_raddr;
  assign data_interface_waddr      = r_waddr;
  assign data_interface_wdata      = r_wdata;
  assign data_interface_call_begin = r_call_begin;

endmodule

// File: tb/tb_data_store_buffer.sv
// Scoreboard bench for data_store_buffer: stimulus pushes expected
// transactions / load data into queues, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_data_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_we = 1'b0;
  logic [2:0]    cpu_req_size = '0;
  logic [31:0]   cpu_req_addr = '0;
  logic [31:0]   cpu_req_wdata = '0;
  logic          cpu_req_ready;
  logic          cpu_rdata_valid;
  logic [31:0]   cpu_rdata;
  logic          sb_empty;
  logic [PTR_W:0] sb_count;
  logic          write_enable;
  logic [2:0]    read_size, write_size;
  logic [31:0]   data_interface_raddr, data_interface_waddr, data_interface_wdata;
  logic          data_interface_call_begin;
  logic          data_interface_return_ready = 1'b0;
  logic [31:0]   data_interface_rdata = '0;

  data_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_size(cpu_req_size), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(cpu_req_ready),
    .cpu_rdata_valid(cpu_rdata_valid), .cpu_rdata(cpu_rdata),
    .sb_empty(sb_empty), .sb_count(sb_count),
    .write_enable(write_enable), .read_size(read_size), .write_size(write_size),
    .data_interface_raddr(data_interface_raddr),
    .data_interface_waddr(data_interface_waddr),
    .data_interface_wdata(data_interface_wdata),
    .data_interface_call_begin(data_interface_call_begin),
    .data_interface_return_ready(data_interface_return_ready),
    .data_interface_rdata(data_interface_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] exp_rd[$];
  int          call_cyc[$];
  int n_vec = 0;
  int n_bad = 0;
  int calls = 0;
  int served = 0;
  int acc_cyc = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic txn_t mk(logic we, logic [31:0] a, logic [31:0] d, logic [2:0] sz);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.size = sz;
    return t;
  endfunction

  function automatic int call_at(int i);
    if (i < call_cyc.size()) return call_cyc[i];
    return -1000;
  endfunction

  // monitor: every call_begin and every load-data pulse is checked against the queues
  always @(negedge clk) begin : mon
    txn_t e;
    logic [31:0] r;
    if (data_interface_call_begin) begin
      calls++;
      call_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_call", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("call #%0d at cycle %0d: we=%0d waddr=0x%08h raddr=0x%08h wdata=0x%08h",
                 calls, cyc, write_enable, data_interface_waddr, data_interface_raddr,
                 data_interface_wdata);
        chk("call_we", 32'(write_enable), 32'(e.we));
        if (e.we) begin
          chk("call_waddr", data_interface_waddr, e.addr);
          chk("call_wdata", data_interface_wdata, e.data);
          chk("call_wsize", 32'(write_size), 32'(e.size));
        end else begin
          chk("call_raddr", data_interface_raddr, e.addr);
          chk("call_rsize", 32'(read_size), 32'(e.size));
        end
      end
    end
    if (cpu_rdata_valid) begin
      if (exp_rd.size() == 0) begin
        chk("unexpected_rdata", 32'd1, 32'd0);
      end else begin
        r = exp_rd.pop_front();
        $display("load data at cycle %0d: 0x%08h", cyc, cpu_rdata);
        chk("load_rdata", cpu_rdata, r);
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] sz);
    int n;
    n = 0;
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = a;
    cpu_req_wdata = d; cpu_req_size = sz;
    forever begin
      @(negedge clk);
      if (cpu_req_ready) break;
      n++;
      if (n > 200) begin
        chk("req_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
  endtask

  // wait for the next unserved call_begin, return in the WAIT cycle after it
  task automatic wait_call();
    int n;
    n = 0;
    while (calls <= served) begin
      @(negedge clk); #1;
      n++;
      if (n > 200) begin
        chk("call_timeout", 32'(calls), 32'(served + 1));
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic ret(input logic [31:0] rd);
    data_interface_return_ready = 1'b1;
    data_interface_rdata = rd;
    @(posedge clk); #1;
    data_interface_return_ready = 1'b0;
  endtask

  task automatic serve(input int extra, input logic [31:0] rd);
    wait_call();
    repeat (extra) begin @(posedge clk); #1; end
    ret(rd);
    served++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    // ---- reset values
    #2;
    chk("rst_ready", 32'(cpu_req_ready), 32'd0);
    chk("rst_empty", 32'(sb_empty), 32'd0);
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_call",  32'(data_interface_call_begin), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_empty", 32'(sb_empty), 32'd1);
    chk("post_rst_count", 32'(sb_count), 32'd0);
    chk("post_rst_ready", 32'(cpu_req_ready), 32'd1);
    chk("post_rst_nocall", 32'(calls), 32'd0);

    // ---- single store, return 5 cycles after call_begin
    exp_q.push_back(mk(1'b1, 32'h8000_1004, 32'hDEAD_BEEF, 3'b100));
    send(1'b1, 32'h8000_1004, 32'hDEAD_BEEF, 3'b100);
    chk("s1_count", 32'(sb_count), 32'd1);
    chk("s1_empty", 32'(sb_empty), 32'd0);
    serve(4, 32'd0);
    chk("s1_latency", 32'(call_at(0) - acc_cyc), 32'd1);
    chk("s1_count_after", 32'(sb_count), 32'd0);
    chk("s1_empty_after", 32'(sb_empty), 32'd1);

    // ---- fill: 5th store refused while full, accepted after one return
    for (int i = 0; i < 5; i++)
      exp_q.push_back(mk(1'b1, 32'h1000 + 32'(16 * i), 32'hA000_0000 + 32'(i), 3'b010));
    for (int i = 0; i < 4; i++)
      send(1'b1, 32'h1000 + 32'(16 * i), 32'hA000_0000 + 32'(i), 3'b010);
    chk("fill_count", 32'(sb_count), 32'd4);
    fork
      send(1'b1, 32'h1040, 32'hA000_0004, 3'b010);
      begin
        @(negedge clk);
        chk("full_ready", 32'(cpu_req_ready), 32'd0);
        @(posedge clk); #1;
        data_interface_return_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", 32'(cpu_req_ready), 32'd0);
        @(posedge clk); #1;
        data_interface_return_ready = 1'b0;
        served++;
      end
    join
    chk("refill_count", 32'(sb_count), 32'd4);
    repeat (4) serve(0, 32'd0);
    chk("fill_drained", 32'(sb_count), 32'd0);

`ifndef SB_LOAD_BYPASS_EN
    // ---- load behind two stores waits for both returns
    exp_q.push_back(mk(1'b1, 32'h8000_3000, 32'h1111_1111, 3'b001));
    exp_q.push_back(mk(1'b1, 32'h8000_3004, 32'h2222_2222, 3'b100));
    exp_q.push_back(mk(1'b0, 32'h8000_2000, 32'h0, 3'b100));
    exp_rd.push_back(32'h1234_5678);
    send(1'b1, 32'h8000_3000, 32'h1111_1111, 3'b001);
    send(1'b1, 32'h8000_3004, 32'h2222_2222, 3'b100);
    send(1'b0, 32'h8000_2000, 32'h0, 3'b100);
    chk("ld_held_ready", 32'(cpu_req_ready), 32'd0);
    serve(1, 32'd0);
    chk("ld_not_early", 32'(calls), 32'(served));
    serve(0, 32'd0);
    serve(0, 32'h1234_5678);
    chk("ld_valid_pulse", 32'(cpu_rdata_valid), 32'd1);
    @(posedge clk); #1;
    chk("ld_valid_drop", 32'(cpu_rdata_valid), 32'd0);
    chk("ld_rdata_hold", cpu_rdata, 32'h1234_5678);
    chk("ld_ready_again", 32'(cpu_req_ready), 32'd1);
`else
    // ---- bypass: non-matching load passes queued stores (blocker holds the engine)
    exp_q.push_back(mk(1'b1, 32'h0000_0010, 32'hB0, 3'b100));
    exp_q.push_back(mk(1'b0, 32'h0000_0300, 32'h0, 3'b100));
    exp_q.push_back(mk(1'b1, 32'h0000_0100, 32'hB1, 3'b100));
    exp_q.push_back(mk(1'b1, 32'h0000_0200, 32'hB2, 3'b100));
    exp_rd.push_back(32'h3333_3333);
    send(1'b1, 32'h0000_0010, 32'hB0, 3'b100);
    send(1'b1, 32'h0000_0100, 32'hB1, 3'b100);
    send(1'b1, 32'h0000_0200, 32'hB2, 3'b100);
    send(1'b0, 32'h0000_0300, 32'h0, 3'b100);
    serve(0, 32'd0);
    serve(0, 32'h3333_3333);
    serve(0, 32'd0);
    serve(0, 32'd0);
    // same-word load (0x202 lies in the word of the 0x200 store) drains first
    exp_q.push_back(mk(1'b1, 32'h0000_0014, 32'hC0, 3'b100));
    exp_q.push_back(mk(1'b1, 32'h0000_0100, 32'hC1, 3'b100));
    exp_q.push_back(mk(1'b1, 32'h0000_0200, 32'hC2, 3'b100));
    exp_q.push_back(mk(1'b0, 32'h0000_0202, 32'h0, 3'b010));
    exp_rd.push_back(32'h4444_4444);
    send(1'b1, 32'h0000_0014, 32'hC0, 3'b100);
    send(1'b1, 32'h0000_0100, 32'hC1, 3'b100);
    send(1'b1, 32'h0000_0200, 32'hC2, 3'b100);
    send(1'b0, 32'h0000_0202, 32'h0, 3'b010);
    serve(0, 32'd0);
    serve(0, 32'd0);
    serve(0, 32'd0);
    serve(0, 32'h4444_4444);
    @(posedge clk); #1;
`endif

    // ---- spacing: immediate returns give call_begin exactly 3 cycles apart
    base = calls;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk(1'b1, 32'h2000 + 32'(4 * i), 32'hC0 + 32'(i), 3'b100));
    for (int i = 0; i < 4; i++)
      send(1'b1, 32'h2000 + 32'(4 * i), 32'hC0 + 32'(i), 3'b100);
    repeat (4) serve(0, 32'd0);
    chk("gap_min3", 32'((call_at(base + 1) - call_at(base)) >= 3), 32'd1);
    chk("gap_2_3", 32'(call_at(base + 2) - call_at(base + 1)), 32'd3);
    chk("gap_3_4", 32'(call_at(base + 3) - call_at(base + 2)), 32'd3);

    // ---- reset while waiting for return_ready
    exp_q.push_back(mk(1'b1, 32'h3000, 32'h55, 3'b100));
    send(1'b1, 32'h3000, 32'h55, 3'b100);
    wait_call();
    served++;
    resetn = 1'b0;
    #1;
    chk("rstw_we",    32'(write_enable), 32'd0);
    chk("rstw_waddr", data_interface_waddr, 32'd0);
    chk("rstw_wdata", data_interface_wdata, 32'd0);
    chk("rstw_count", 32'(sb_count), 32'd0);
    chk("rstw_empty", 32'(sb_empty), 32'd0);
    chk("rstw_ready", 32'(cpu_req_ready), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    chk("rstw_empty_after", 32'(sb_empty), 32'd1);
    chk("rstw_count_after", 32'(sb_count), 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    chk("rstw_nocall", 32'(calls), 32'(served));

    chk("exp_calls_left", 32'(exp_q.size()), 32'd0);
    chk("exp_rdata_left", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
